// File: rtl/text_tx_framer_if.sv
// Bundle between user logic, the text framer and the UART TX byte stream.
// The slave side is the framer; the master side is user logic plus the UART TX.
interface text_tx_framer_if #(
    parameter int MAX_BYTES = 32
);
    logic [MAX_BYTES*8-1:0] text_bytes;
    logic [7:0]             text_size;
    logic                   text_send;
    logic                   busy;
    logic                   done;
    logic                   truncated;
    logic [7:0]             tx_byte;
    logic                   tx_valid;
    logic                   tx_ready;

    modport master (
        output text_bytes, text_size, text_send, tx_ready,
        input  busy, done, truncated, tx_byte, tx_valid
    );

    modport slave (
        input  text_bytes, text_size, text_send, tx_ready,
        output busy, done, truncated, tx_byte, tx_valid
    );
endinterface

// File: rtl/text_tx_framer.sv
// Frames a text buffer as TAG, LEN, payload and streams it over a valid/ready byte port.
// Optional trailing XOR checksum byte when TEXT_TX_CHECKSUM_EN is defined.
module text_tx_framer #(
    parameter int         MAX_BYTES = 32,
    parameter logic [7:0] TEXT_TAG  = 8'h03
) (
    input  logic             CLK,
    input  logic             RST,
    text_tx_framer_if.slave  bus
);
    localparam int         IDX_W   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);

    typedef enum logic [2:0] {IDLE, TAG, LEN, PAYLOAD, CSUM} state_t;

    state_t                 state;
    logic [MAX_BYTES*8-1:0] snap;
    logic [7:0]             len;
    logic [IDX_W-1:0]       idx;
`ifdef TEXT_TX_CHECKSUM_EN
    logic [7:0]             csum;
`endif

    function automatic logic [7:0] pick(input logic [MAX_BYTES*8-1:0] b,
                                        input logic [IDX_W-1:0] k);
        return b[{k, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] clamp_len(input logic [7:0] size);
        return (size > MAX_LEN) ? MAX_LEN : size;
    endfunction

    // Snapshot registers (snap, len, idx, csum) carry no reset; only control state does.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.truncated <= 1'b0;
            bus.tx_valid  <= 1'b0;
            bus.tx_byte   <= 8'h00;
        end else begin
            bus.done      <= 1'b0;
            bus.truncated <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.text_send) begin
                        snap          <= bus.text_bytes;
                        len           <= clamp_len(bus.text_size);
                        bus.truncated <= (bus.text_size > MAX_LEN);
                        bus.busy      <= 1'b1;
                        bus.tx_valid  <= 1'b1;
                        bus.tx_byte   <= TEXT_TAG;
`ifdef TEXT_TX_CHECKSUM_EN
                        csum          <= TEXT_TAG ^ clamp_len(bus.text_size);
`endif
                        state         <= TAG;
                    end
                end
                TAG: begin
                    if (bus.tx_ready) begin
                        bus.tx_byte <= len;
                        state       <= LEN;
                    end
                end
                LEN: begin
                    if (bus.tx_ready) begin
                        if (len == 8'd0) begin
`ifdef TEXT_TX_CHECKSUM_EN
                            bus.tx_byte  <= csum;
                            state        <= CSUM;
`else
                            bus.tx_valid <= 1'b0;
                            bus.busy     <= 1'b0;
                            bus.done     <= 1'b1;
                            state        <= IDLE;
`endif
                        end else begin
                            idx         <= '0;
                            bus.tx_byte <= pick(snap, '0);
                            state       <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (bus.tx_ready) begin
`ifdef TEXT_TX_CHECKSUM_EN
                        csum <= csum ^ pick(snap, idx);
`endif
                        // idx never passes len-1, so it cannot wrap
                        if (8'(idx) == len - 8'd1) begin
`ifdef TEXT_TX_CHECKSUM_EN
                            bus.tx_byte  <= csum ^ pick(snap, idx);
                            state        <= CSUM;
`else
                            bus.tx_valid <= 1'b0;
                            bus.busy     <= 1'b0;
                            bus.done     <= 1'b1;
                            state        <= IDLE;
`endif
                        end else begin
                            idx         <= idx + 1'b1;
                            bus.tx_byte <= pick(snap, idx + 1'b1);
                        end
                    end
                end
                CSUM: begin
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_text_tx_framer.sv
// Bench for text_tx_framer: queue-of-bytes reference model checked every cycle,
// directed frames pinned with literal byte lists, then randomized frames and stalls.
module tb_text_tx_framer;
    localparam int         MAX_BYTES = 32;
    localparam logic [7:0] TAG       = 8'h03;
`ifdef TEXT_TX_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    text_tx_framer_if #(.MAX_BYTES(MAX_BYTES)) bus ();

    text_tx_framer #(.MAX_BYTES(MAX_BYTES), .TEXT_TAG(TAG)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] got[$];
    bit   m_live = 0, m_done = 0, m_trunc = 0, m_zero = 0;
    int   done_cnt = 0, trunc_cnt = 0, busy_cnt = 0;
    int   ready_mode = 0;
    int   m_n;
    logic [7:0] m_x;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is the list of bytes still owed; valid/busy = list non-empty.
    always @(negedge CLK) begin
        if (m_live) begin
            chk("tx_valid", 32'(bus.tx_valid), 32'(q.size() > 0));
            chk("busy", 32'(bus.busy), 32'(q.size() > 0));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("truncated", 32'(bus.truncated), 32'(m_trunc));
            if (q.size() > 0)
                chk("tx_byte", 32'(bus.tx_byte), 32'(q[0]));
            else if (m_zero)
                chk("tx_byte_reset", 32'(bus.tx_byte), 32'h0);
            if (bus.done === 1'b1) done_cnt++;
            if (bus.truncated === 1'b1) trunc_cnt++;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.tx_valid === 1'b1 && bus.tx_ready && !RST) got.push_back(bus.tx_byte);
        end
        m_done  = 0;
        m_trunc = 0;
        if (RST) begin
            q.delete();
            m_live = 1;
            m_zero = 1;
        end else if (m_live) begin
            if (q.size() > 0) begin
                if (bus.tx_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_done = 1;
                end
            end else if (bus.text_send) begin
                m_n     = (bus.text_size > MAX_BYTES) ? MAX_BYTES : int'(bus.text_size);
                m_trunc = (bus.text_size > MAX_BYTES);
                m_zero  = 0;
                m_x     = TAG ^ 8'(m_n);
                q.push_back(TAG);
                q.push_back(8'(m_n));
                for (int k = 0; k < m_n; k++) begin
                    q.push_back(bus.text_bytes[8*k +: 8]);
                    m_x = m_x ^ bus.text_bytes[8*k +: 8];
                end
                if (CS) q.push_back(m_x);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        case (ready_mode)
            0: bus.tx_ready = 1'b1;
            1: bus.tx_ready = ~bus.tx_ready;
            default: bus.tx_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic send(input logic [MAX_BYTES*8-1:0] b, input logic [7:0] size);
        bus.text_bytes = b;
        bus.text_size  = size;
        bus.text_send  = 1'b1;
        tick();
        bus.text_send  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start;
        start = done_cnt;
        for (int i = 0; i < 400; i++) begin
            if (done_cnt > start) break;
            tick();
        end
        chk({name, "_done_seen"}, 32'(done_cnt > start), 32'h1);
    endtask

    task automatic cmp_frame(input string name, input logic [7:0] exp[$]);
        chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            chk({name, "_byte"}, 32'(got[i]), 32'(exp[i]));
    endtask

    logic [MAX_BYTES*8-1:0] abc, buf_a, buf_b, rnd;
    logic [7:0] exp[$];
    int b0, d0, t0;

    initial begin
        bus.text_bytes = '0;
        bus.text_size  = 8'd0;
        bus.text_send  = 1'b0;
        bus.tx_ready   = 1'b1;
        abc = '0;
        abc[23:0] = 24'h636261;
        repeat (3) tick();
        RST = 1'b0;
        tick();

        // "abc" at full rate
        ready_mode = 0;
        got.delete();
        b0 = busy_cnt; d0 = done_cnt;
        send(abc, 8'd3);
        wait_done("t1");
        tick(); tick();
        if (CS) exp = '{8'h03, 8'h03, 8'h61, 8'h62, 8'h63, 8'h60};
        else    exp = '{8'h03, 8'h03, 8'h61, 8'h62, 8'h63};
        cmp_frame("t1", exp);
        chk("t1_busy_cycles", 32'(busy_cnt - b0), CS ? 32'd6 : 32'd5);
        chk("t1_done_count", 32'(done_cnt - d0), 32'd1);

        // same frame with tx_ready toggling
        ready_mode = 1;
        got.delete();
        send(abc, 8'd3);
        wait_done("t2");
        tick();
        cmp_frame("t2", exp);

        // empty payload
        ready_mode = 0;
        got.delete();
        send(abc, 8'd0);
        wait_done("t3");
        tick();
        if (CS) exp = '{8'h03, 8'h00, 8'h03};
        else    exp = '{8'h03, 8'h00};
        cmp_frame("t3", exp);

        // oversize request is clamped
        for (int k = 0; k < MAX_BYTES; k++) rnd[8*k +: 8] = 8'($urandom);
        got.delete();
        t0 = trunc_cnt;
        send(rnd, 8'd40);
        wait_done("t4");
        tick();
        chk("t4_trunc_pulses", 32'(trunc_cnt - t0), 32'd1);
        chk("t4_len_byte", 32'(got[1]), 32'h20);
        chk("t4_frame_len", 32'(got.size()), CS ? 32'd35 : 32'd34);
        for (int k = 0; k < MAX_BYTES; k++)
            chk("t4_payload", 32'(got[2+k]), 32'(rnd[8*k +: 8]));

        // second request while busy is ignored
        buf_a = '0;
        buf_a[39:0] = 40'h1413121110;
        buf_b = '1;
        got.delete();
        send(buf_a, 8'd5);
        tick();
        bus.text_bytes = buf_b;
        bus.text_size  = 8'd9;
        bus.text_send  = 1'b1;
        tick();
        bus.text_send  = 1'b0;
        wait_done("t5");
        tick();
        if (CS) exp = '{8'h03, 8'h05, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h12};
        else    exp = '{8'h03, 8'h05, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        cmp_frame("t5", exp);

        // reset after the second payload byte aborts the frame
        got.delete();
        d0 = done_cnt;
        send(buf_b, 8'd10);
        for (int i = 0; i < 50; i++) begin
            if (got.size() >= 4) break;
            tick();
        end
        chk("t6_reached_payload", 32'(got.size() >= 4), 32'h1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        chk("t6_valid_low", 32'(bus.tx_valid), 32'h0);
        chk("t6_busy_low", 32'(bus.busy), 32'h0);
        tick(); tick();
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
        got.delete();
        send(abc, 8'd3);
        wait_done("t6b");
        tick();
        if (CS) exp = '{8'h03, 8'h03, 8'h61, 8'h62, 8'h63, 8'h60};
        else    exp = '{8'h03, 8'h03, 8'h61, 8'h62, 8'h63};
        cmp_frame("t6b", exp);

        // randomized frames, stalls and stray requests
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < MAX_BYTES; k++) rnd[8*k +: 8] = 8'($urandom);
            send(rnd, 8'($urandom_range(0, 45)));
            if ($urandom_range(0, 1) == 1) begin
                bus.text_bytes = ~rnd;
                bus.text_size  = 8'($urandom_range(0, 45));
                bus.text_send  = 1'b1;
                tick();
                bus.text_send  = 1'b0;
            end
            wait_done("rand");
            repeat ($urandom_range(0, 2)) tick();
        end
        ready_mode = 0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
